serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Serial frame transmitter: the sending end of the team's port-addressed serial link. Accepts a parallel request (destination port, data length, data word) and serializes it onto a single line as start bit, 2-bit port number, 4-bit data count, then the data bits. The line is read by the port-demultiplexing receiver, which routes payload bits to output P0..P3. All shifting and counting advance only on clock-enable ticks, matching the receiver's enable-paced timing.

## Interface
- DATA_W, 15, payload register width; must be at least 15 so every 4-bit count (0..15) is sendable.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clkEn  in  1  bit-rate enable; state advances only on clk edges where clkEn=1.
- start  in  1  request strobe; sampled only in IDLE on an enabled edge.
- portNum  in  2  destination port, captured with start.
- numData  in  4  payload bit count 0..15, captured with start.
- dataIn  in  DATA_W  payload, captured with start; bit 0 is sent first.
- serOut  out  1  serial line; idles high.
- busy  out  1  high from START through the last DATA bit.
- done  out  1  high during the single DONE enabled cycle.
- remaining  out  4  payload bits still to send; feeds an SSD.

## Operation
- Reset (rst=0, asynchronous): state=IDLE, serOut=1, busy=0, done=0, remaining=0, and all capture registers cleared.
- The FSM has six states: IDLE, START, PORT, COUNT, DATA, DONE. All outputs are registered.
- IDLE: serOut=1. On an enabled edge with start=1, capture portNum, numData and dataIn, set remaining=numData, and go to START.
- START: serOut=0 for one enabled cycle, then go to PORT.
- PORT: send portNum MSB first over 2 enabled cycles, then go to COUNT.
- COUNT: send numData MSB first over 4 enabled cycles. Then go to DATA if numData≠0, otherwise go directly to DONE.
- DATA: serOut = the current LSB of the payload shift register. On each enabled edge, shift right and decrement remaining. Leave for DONE when the bit with remaining=1 has been sent; remaining then reads 0.
- DONE: serOut=1, done=1 for one enabled cycle, then go to IDLE.
- start in any state other than IDLE is ignored. Captured values do not change mid-frame when the inputs change.
- Data bits at index ≥ numData are never sent.
- When clkEn=0, state, serOut and every counter hold. done stays high if DONE is held.
- Reset asserted mid-frame aborts immediately: serOut=1, no partial completion, no done pulse.

## Timing
- Every enabled edge is one bit time. Frame length is 7+N bit times, where N=numData. DONE adds one further high bit time.
- Latency: start sampled at enabled edge E0 → serOut=0 after E0. Port MSB follows after E1, count MSB after E3, data bit 0 after E7. done=1 after edge E(7+N).
- Back-to-back frames: start may be asserted during DONE but is not sampled until IDLE. The minimum gap is therefore DONE plus IDLE, i.e. two idle-high bit times between frames.
- busy rises on the edge that enters START. It falls on the edge that enters DONE.
- remaining is stable during START/PORT/COUNT and is decremented on the same edge that advances the data bit.

## Test plan
- Reset: hold rst=0 with random inputs → serOut=1, busy=0, done=0, remaining=0. Release rst, clkEn=1, start=0 for 10 cycles → outputs unchanged.
- Basic frame: portNum=2'b10, numData=4'd5, dataIn=15'h0015, clkEn=1 → serOut sequence 0,1,0,0,1,0,1,1,0,1,0,1 then 1 with done=1. remaining steps 5,4,3,2,1,0.
- Zero-length: portNum=2'b11, numData=0 → serOut 0,1,1,0,0,0,0, then DONE (done=1) with no data bits.
- Enable pacing: same frame as the basic case with clkEn high one cycle in three → identical bit sequence, each bit held exactly three clk cycles. done is high for three clk cycles.
- Ignored start and maximum length: numData=15, dataIn=15'h7FFF, start re-pulsed with different inputs mid-frame → the original 22-bit frame completes unchanged, with all 15 data bits=1.
- Mid-frame reset: assert rst=0 during DATA → serOut=1 and busy=0 immediately, with no done. After release, a new frame transmits correctly.

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// Request/line bundle between a frame requester and the serial frame transmitter.
// The master side issues requests and observes the line; the slave side is the transmitter.
interface serial_frame_tx_if #(parameter int DATA_W = 15);
    logic              clkEn;
    logic              start;
    logic [1:0]        portNum;
    logic [3:0]        numData;
    logic [DATA_W-1:0] dataIn;
    logic              serOut;
    logic              busy;
    logic              done;
    logic [3:0]        remaining;

    modport master (
        output clkEn, start, portNum, numData, dataIn,
        input  serOut, busy, done, remaining
    );

    modport slave (
        input  clkEn, start, portNum, numData, dataIn,
        output serOut, busy, done, remaining
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Serializes a port-addressed request as start bit, 2-bit port, 4-bit count, then payload LSB first.
// Every state change and shift is paced by clkEn so one enabled edge equals one bit time.
module serial_frame_tx #(
    parameter int DATA_W = 15
) (
    input logic               clk_i,
    input logic               rst_ni,
    serial_frame_tx_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, START, PORT, COUNT, DATA, DONE} state_e;

    state_e            state_q, state_d;
    logic              serOut_q, serOut_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        remaining_q, remaining_d;
    logic [3:0]        count_q, count_d;
    logic [1:0]        port_q, port_d;
    logic [1:0]        bitIdx_q, bitIdx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [1:0]        nextIdx;

    assign nextIdx = bitIdx_q - 2'd1;

    // Outputs are computed for the state being entered, so the line changes right after each enabled edge.
    always_comb begin
        state_d     = state_q;
        serOut_d    = serOut_q;
        busy_d      = busy_q;
        done_d      = done_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        port_d      = port_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        if (bus.clkEn) begin
            case (state_q)
                IDLE: begin
                    serOut_d = 1'b1;
                    if (bus.start) begin
                        state_d     = START;
                        port_d      = bus.portNum;
                        count_d     = bus.numData;
                        shift_d     = bus.dataIn;
                        remaining_d = bus.numData;
                        serOut_d    = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
                START: begin
                    state_d  = PORT;
                    bitIdx_d = 2'd1;
                    serOut_d = port_q[1];
                end
                PORT: begin
                    if (bitIdx_q != 2'd0) begin
                        bitIdx_d = nextIdx;
                        serOut_d = port_q[0];
                    end else begin
                        state_d  = COUNT;
                        bitIdx_d = 2'd3;
                        serOut_d = count_q[3];
                    end
                end
                COUNT: begin
                    if (bitIdx_q != 2'd0) begin
                        bitIdx_d = nextIdx;
                        serOut_d = count_q[nextIdx];
                    end else if (count_q != 4'd0) begin
                        state_d  = DATA;
                        serOut_d = shift_q[0];
                    end else begin
                        state_d  = DONE;
                        serOut_d = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
                DATA: begin
                    // remaining counts the bit currently on the line, so 1 means the last bit is out.
                    if (remaining_q == 4'd1) begin
                        state_d     = DONE;
                        remaining_d = 4'd0;
                        serOut_d    = 1'b1;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        shift_d     = shift_q >> 1;
                        serOut_d    = shift_q[1];
                        remaining_d = remaining_q - 4'd1;
                    end
                end
                DONE: begin
                    state_d  = IDLE;
                    serOut_d = 1'b1;
                    done_d   = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    serOut_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            serOut_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= 4'd0;
            count_q     <= 4'd0;
            port_q      <= 2'd0;
            bitIdx_q    <= 2'd0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            serOut_q    <= serOut_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            port_q      <= port_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
        end
    end

    assign bus.serOut    = serOut_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized bench for serial_frame_tx: a queue-based frame model predicts the line every cycle,
// and literal bit sequences pin the model for the hand-worked frames.
module tb_serial_frame_tx;

    typedef struct packed {
        logic       ser;
        logic       busy;
        logic       done;
        logic [3:0] rem;
    } outT;

    localparam outT IDLE_OUT = '{ser: 1'b1, busy: 1'b0, done: 1'b0, rem: 4'd0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   enPeriod = 1;
    int   enCnt = 0;
    bit   enRandom = 1'b0;
    bit   enSeen = 1'b0;
    int   doneCycles = 0;
    outT  cur = IDLE_OUT;
    outT  expQ[$];
    bit   lineLog[$];

    serial_frame_tx_if #(.DATA_W(15)) bus();

    serial_frame_tx #(.DATA_W(15)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expand a request into the full list of per-bit-time outputs, DONE included.
    task automatic buildFrame(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d);
        int nInt;
        nInt = int'(n);
        expQ.push_back('{1'b0, 1'b1, 1'b0, n});
        expQ.push_back('{p[1], 1'b1, 1'b0, n});
        expQ.push_back('{p[0], 1'b1, 1'b0, n});
        for (int i = 3; i >= 0; i--) expQ.push_back('{n[i], 1'b1, 1'b0, n});
        for (int k = 0; k < nInt; k++) expQ.push_back('{d[k], 1'b1, 1'b0, 4'(nInt - k)});
        expQ.push_back('{1'b1, 1'b0, 1'b1, 4'd0});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
            cur = IDLE_OUT;
            enSeen = 1'b0;
        end else begin
            enSeen = bus.clkEn;
            if (bus.clkEn) begin
                if (expQ.size() != 0) cur = expQ.pop_front();
                else if (!cur.busy && !cur.done && bus.start) begin
                    buildFrame(bus.portNum, bus.numData, bus.dataIn);
                    cur = expQ.pop_front();
                end else cur = IDLE_OUT;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("cycle", {25'b0, bus.serOut, bus.busy, bus.done, bus.remaining}, {25'b0, cur});
            if (enSeen && bus.busy === 1'b1) lineLog.push_back(bus.serOut);
        end
    end

    always @(negedge clk) begin
        if (enRandom) bus.clkEn = 1'($urandom_range(0, 1));
        else begin
            bus.clkEn = (enCnt == 0);
            enCnt = (enCnt + 1 >= enPeriod) ? 0 : enCnt + 1;
        end
    end

    task automatic randomizeInputs();
        bus.portNum = 2'($urandom_range(0, 3));
        bus.numData = 4'($urandom_range(0, 15));
        bus.dataIn  = 15'($urandom);
    endtask

    task automatic applyStimulus(input logic [1:0] p, input logic [3:0] n, input logic [14:0] d, input bit pulseMid);
        int guard;
        lineLog.delete();
        doneCycles = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.portNum = p;
        bus.numData = n;
        bus.dataIn = d;
        guard = 0;
        while (bus.busy !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("busyTimeout", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        randomizeInputs();
        if (pulseMid) begin
            repeat (5) @(negedge clk);
            bus.start = 1'b1;
            randomizeInputs();
            repeat (3) @(negedge clk);
            bus.start = 1'b0;
        end
        guard = 0;
        while (bus.done !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) checkOutput("doneTimeout", 32'(bus.done), 32'd1);
        guard = 0;
        while (bus.done === 1'b1 && guard < 100) begin
            doneCycles++;
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic checkSeq(input string name, input logic [31:0] expected, input int len);
        logic [31:0] got;
        got = '0;
        for (int i = 0; i < lineLog.size() && i < 32; i++) got = {got[30:0], 1'(lineLog[i])};
        checkOutput({name, "Len"}, 32'(lineLog.size()), 32'(len));
        checkOutput({name, "Bits"}, got, expected);
    endtask

    initial begin
        int guard;
        bus.start = 1'b0;
        bus.clkEn = 1'b1;
        randomizeInputs();

        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'($urandom_range(0, 1));
            randomizeInputs();
            #1;
            checkOutput("rstSer", 32'(bus.serOut), 32'd1);
            checkOutput("rstBusy", 32'(bus.busy), 32'd0);
            checkOutput("rstDone", 32'(bus.done), 32'd0);
            checkOutput("rstRem", 32'(bus.remaining), 32'd0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("idleOut", {28'b0, bus.serOut, bus.busy, bus.done, 1'b0}, 32'h8);

        applyStimulus(2'b10, 4'd5, 15'h0015, 1'b0);
        checkSeq("basicSeq", 32'b010010110101, 12);
        checkOutput("basicDoneLen", 32'(doneCycles), 32'd1);

        applyStimulus(2'b11, 4'd0, 15'h7ABC, 1'b0);
        checkSeq("zeroSeq", 32'b0110000, 7);
        checkOutput("zeroDoneLen", 32'(doneCycles), 32'd1);

        enPeriod = 3;
        enCnt = 0;
        applyStimulus(2'b10, 4'd5, 15'h0015, 1'b0);
        checkSeq("pacedSeq", 32'b010010110101, 12);
        checkOutput("pacedDoneLen", 32'(doneCycles), 32'd3);

        enPeriod = 1;
        enCnt = 0;
        applyStimulus(2'b01, 4'd15, 15'h7FFF, 1'b1);
        checkSeq("maxSeq", 32'h000FFFFF, 22);

        @(negedge clk);
        bus.start = 1'b1;
        bus.portNum = 2'b10;
        bus.numData = 4'd10;
        bus.dataIn = 15'h2AA;
        guard = 0;
        while (bus.busy !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abortSer", 32'(bus.serOut), 32'd1);
        checkOutput("abortBusy", 32'(bus.busy), 32'd0);
        checkOutput("abortRem", 32'(bus.remaining), 32'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abortNoDone", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        applyStimulus(2'b10, 4'd5, 15'h0015, 1'b0);
        checkSeq("afterAbortSeq", 32'b010010110101, 12);

        for (int f = 0; f < 25; f++) begin
            enRandom = (f % 3 == 2);
            enPeriod = $urandom_range(1, 3);
            enCnt = 0;
            applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 15'($urandom), 1'($urandom_range(0, 1)));
            checkOutput("randFrameLen", 32'(lineLog.size()), 32'(7 + int'(dut.count_q)));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        enRandom = 1'b0;
        enPeriod = 1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
